hand_paddle: RTL and testbench

Upstream stage of the ball-physics block. Turns two raw push-buttons into the catcher position `handline` and the catcher upward-swing speed `hand_velocity`, both consumed by the bounce engine. Position and speed update once per physics frame, on the same ~18.2 ms cadence as the bounce engine. A lock input freezes the paddle when the game is over.

---
 rtl/ballplayer_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 45 ++++
 rtl/hand_paddle.sv | 147 ++++++++++++++
 tb/tb_hand_paddle.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ballplayer_pkg.sv
// rtl/ballplayer_pkg.sv - shared ball-physics constants and paddle state encoding
package ballplayer_pkg;

   // Screen height shared with the bounce engine.
   localparam int SCREEN_MAX_Y = 309;

   // Clock cycles per physics frame (12 MHz -> ~18.2 ms).
   localparam int FRAME_DIV = 219089;

   typedef enum logic [1:0] {
      PS_IDLE = 2'd0,
      PS_UP   = 2'd1,
      PS_DOWN = 2'd2
   } paddle_state_t;

   // Clip an unsigned value into the 8-bit velocity range.
   function automatic logic [7:0] sat255(input logic [9:0] v);
      return (v > 10'd255) ? 8'd255 : v[7:0];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer followed by a stable-count debouncer
module btn_debounce #(
   parameter int DB_CYCLES = 60000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_dout;
   logic [CW-1:0] r_cnt;

   // Synchronize the raw button and flip the debounced level only after it has
   // disagreed for DB_CYCLES consecutive cycles; any agreement restarts the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_dout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_dout) begin
            if (r_cnt == CNT_LAST) begin
               r_dout <= r_sync2;
               r_cnt  <= '0;
            end else begin
               r_cnt  <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign dout = r_dout;

endmodule

// File: rtl/hand_paddle.sv
// rtl/hand_paddle.sv - button-driven catcher position and upward swing speed per frame
module hand_paddle
   import ballplayer_pkg::*;
#(
   parameter int         TICK_DIV  = FRAME_DIV,
   parameter int         DB_CYCLES = 60000,
   parameter logic [8:0] Y_MIN     = 9'd20,
   parameter logic [8:0] Y_MAX     = 9'd300,
   parameter logic [8:0] HOME_Y    = 9'd200,
   parameter logic [3:0] V0        = 4'd1,
   parameter logic [3:0] ACCEL     = 4'd1,
   parameter logic [3:0] VMAX      = 4'd12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       lock,
   output logic [8:0] handline,
   output logic [7:0] hand_velocity,
   output logic       frame_tick
);

   localparam int FCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(TICK_DIV - 1);

   logic [FCW-1:0] r_frame_cnt;
   logic           w_tick;

   logic           w_up_db;
   logic           w_dn_db;
   logic           w_move_up;
   logic           w_move_dn;

   paddle_state_t  r_state;
   paddle_state_t  w_state_nxt;
   paddle_state_t  w_dir;
   logic [3:0]     r_speed;
   logic [3:0]     w_speed_nxt;
   logic [8:0]     r_handline;
   logic [8:0]     w_handline_nxt;
   logic [7:0]     r_velocity;
   logic [7:0]     w_velocity_nxt;

   logic [4:0]     w_spd_inc;
   logic [3:0]     w_spd;
   logic [9:0]     w_floor;
   logic [9:0]     w_sum_dn;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_up),
      .dout (w_up_db)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_down),
      .dout (w_dn_db)
   );

   // Free-running frame divider; the tick marks the last cycle of each frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (r_frame_cnt == FRAME_LAST) begin
         r_frame_cnt <= '0;
      end else begin
         r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
   end

   assign w_tick = (r_frame_cnt == FRAME_LAST);

   // Lock wins over the buttons; both or neither pressed means no motion.
   assign w_move_up = w_up_db & ~w_dn_db & ~lock;
   assign w_move_dn = w_dn_db & ~w_up_db & ~lock;
   assign w_dir     = w_move_up ? PS_UP : PS_DOWN;

   // Speed restarts at V0 on a new direction, otherwise accelerates up to VMAX.
   assign w_spd_inc = {1'b0, r_speed} + {1'b0, ACCEL};
   assign w_spd     = (r_state != w_dir) ? V0 :
                      ((w_spd_inc > {1'b0, VMAX}) ? VMAX : w_spd_inc[3:0]);

   // 10-bit move arithmetic so neither limit can wrap.
   assign w_floor   = {1'b0, Y_MIN} + {6'd0, w_spd};
   assign w_sum_dn  = {1'b0, r_handline} + {6'd0, w_spd};

   // Next state, speed, position and swing velocity; everything holds off-tick.
   always_comb begin
      w_state_nxt    = r_state;
      w_speed_nxt    = r_speed;
      w_handline_nxt = r_handline;
      w_velocity_nxt = r_velocity;
      if (w_tick) begin
         if (w_move_up) begin
            w_state_nxt = PS_UP;
            if (({1'b0, r_handline} < w_floor) || (r_handline == Y_MIN)) begin
               // Move truncated at the top limit (or no room at all): stop.
               w_handline_nxt = Y_MIN;
               w_speed_nxt    = 4'd0;
            end else begin
               w_handline_nxt = r_handline - {5'd0, w_spd};
               w_speed_nxt    = w_spd;
            end
            w_velocity_nxt = (w_handline_nxt < r_handline) ?
                             sat255({4'd0, w_speed_nxt, 2'b00}) : 8'd0;
         end else if (w_move_dn) begin
            w_state_nxt = PS_DOWN;
            if ((w_sum_dn > {1'b0, Y_MAX}) || (r_handline == Y_MAX)) begin
               w_handline_nxt = Y_MAX;
               w_speed_nxt    = 4'd0;
            end else begin
               w_handline_nxt = w_sum_dn[8:0];
               w_speed_nxt    = w_spd;
            end
            w_velocity_nxt = 8'd0;
         end else begin
            w_state_nxt    = PS_IDLE;
            w_speed_nxt    = 4'd0;
            w_velocity_nxt = 8'd0;
         end
      end
   end

   // Paddle state register; position and velocity update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= PS_IDLE;
         r_speed    <= 4'd0;
         r_handline <= HOME_Y;
         r_velocity <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_speed    <= w_speed_nxt;
         r_handline <= w_handline_nxt;
         r_velocity <= w_velocity_nxt;
      end
   end

   assign handline      = r_handline;
   assign hand_velocity = r_velocity;
   assign frame_tick    = w_tick;

endmodule

// File: tb/tb_hand_paddle.sv
// tb/tb_hand_paddle.sv - self-checking bench for hand_paddle with a frame-level reference model
module tb_hand_paddle;

   localparam int TICK_DIV = 8;
   localparam int DB       = 3;
   localparam int DBL      = 2 + DB;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       lock;
   logic [8:0] handline;
   logic [7:0] hand_velocity;
   logic       frame_tick;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_cnt;
   int m_y;
   int m_vel;
   int m_spd;
   int m_st;      // 0 idle, 1 up, 2 down
   bit m_db_up;
   bit m_db_dn;
   bit hist_up[$];
   bit hist_dn[$];

   always #5 clk = ~clk;

   hand_paddle #(
      .TICK_DIV  (TICK_DIV),
      .DB_CYCLES (DB),
      .Y_MIN     (9'd20),
      .Y_MAX     (9'd300),
      .HOME_Y    (9'd200),
      .V0        (4'd1),
      .ACCEL     (4'd1),
      .VMAX      (4'd12)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .lock          (lock),
      .handline      (handline),
      .hand_velocity (hand_velocity),
      .frame_tick    (frame_tick)
   );

   // Debounced level after an edge: flips only if the last DB synchronized
   // samples (raw samples delayed by two edges) all disagree with it.
   function automatic bit settle(input bit h[$], input bit cur);
      int n = h.size();
      for (int k = 0; k < DB; k++)
         if (h[n - 3 - k] == cur) return cur;
      return !cur;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_y = 200; m_vel = 0; m_spd = 0; m_st = 0;
      m_db_up = 1'b0; m_db_dn = 1'b0;
      hist_up.delete(); hist_dn.delete();
      for (int i = 0; i < DB + 2; i++) begin
         hist_up.push_back(1'b0);
         hist_dn.push_back(1'b0);
      end
   endtask

   task automatic frame_update(input bit du, input bit dd, input bit lk);
      int dir, tgt, ny;
      if (lk || du == dd) begin
         m_st = 0; m_spd = 0; m_vel = 0;
      end else begin
         dir   = du ? 1 : 2;
         m_spd = (m_st != dir) ? 1 : ((m_spd + 1 > 12) ? 12 : m_spd + 1);
         m_st  = dir;
         if (dir == 1) begin
            tgt = m_y - m_spd;
            ny  = (tgt < 20) ? 20 : tgt;
            if (ny == 20 && (tgt < 20 || m_y == 20)) m_spd = 0;
            m_vel = (ny < m_y) ? ((m_spd * 4 > 255) ? 255 : m_spd * 4) : 0;
            m_y   = ny;
         end else begin
            tgt = m_y + m_spd;
            ny  = (tgt > 300) ? 300 : tgt;
            if (ny == 300 && (tgt > 300 || m_y == 300)) m_spd = 0;
            m_vel = 0;
            m_y   = ny;
         end
      end
   endtask

   // One clock edge for DUT and model alike; outputs are sampled 1 ns later.
   task automatic step();
      bit raw_u, raw_d, rs, lk, tk, du, dd;
      raw_u = btn_up; raw_d = btn_down; rs = rst; lk = lock;
      tk = (m_cnt == TICK_DIV - 1);
      du = m_db_up; dd = m_db_dn;
      @(posedge clk);
      #1;
      if (rs) begin
         model_reset();
      end else begin
         if (tk) frame_update(du, dd, lk);
         hist_up.push_back(raw_u);
         hist_dn.push_back(raw_d);
         m_db_up = settle(hist_up, du);
         m_db_dn = settle(hist_dn, dd);
         if (hist_up.size() > 16) begin
            void'(hist_up.pop_front());
            void'(hist_dn.pop_front());
         end
         m_cnt = (m_cnt + 1) % TICK_DIV;
      end
   endtask

   // Advance through the next frame_tick edge, bounded in cycles.
   task automatic wait_frame();
      for (int i = 0; i < 2 * TICK_DIV && frame_tick !== 1'b1; i++) step();
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL wait_frame: frame_tick=%b required 1 within %0d cycles", frame_tick, 2 * TICK_DIV);
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; lock = 1'b0;
      repeat (4) step();
      checks++;
      if (handline !== 9'd200) begin
         errors++; $display("FAIL reset_handline: got %0d required 200", handline);
      end
      checks++;
      if (hand_velocity !== 8'd0) begin
         errors++; $display("FAIL reset_velocity: got %0d required 0", hand_velocity);
      end
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++; $display("FAIL reset_tick: got %b required 0", frame_tick);
      end
      rst = 1'b0;
      for (int k = 1; k < TICK_DIV; k++) begin
         step();
         checks++;
         if (frame_tick !== (k == TICK_DIV - 1)) begin
            errors++;
            $display("FAIL first_tick: cycle %0d got %b required %b", k, frame_tick, (k == TICK_DIV - 1));
         end
      end
   endtask

   task automatic test_hold_up();
      int exp_y[5] = '{199, 197, 194, 190, 185};
      int exp_v[5] = '{4, 8, 12, 16, 20};
      btn_up = 1'b1;
      repeat (DBL) step();
      for (int f = 0; f < 5; f++) begin
         wait_frame();
         checks++;
         if (handline !== exp_y[f][8:0]) begin
            errors++; $display("FAIL hold_up_y: frame %0d got %0d required %0d", f, handline, exp_y[f]);
         end
         checks++;
         if (hand_velocity !== exp_v[f][7:0]) begin
            errors++; $display("FAIL hold_up_vel: frame %0d got %0d required %0d", f, hand_velocity, exp_v[f]);
         end
      end
      btn_up = 1'b0;
      repeat (DBL) step();
      wait_frame();
      checks++;
      if (hand_velocity !== 8'd0 || handline !== 9'd185) begin
         errors++; $display("FAIL release_up: got y=%0d v=%0d required y=185 v=0", handline, hand_velocity);
      end
   endtask

   task automatic test_glitch();
      btn_down = 1'b1;
      step(); step();
      btn_down = 1'b0;
      for (int f = 0; f < 3; f++) begin
         wait_frame();
         checks++;
         if (handline !== 9'd185 || hand_velocity !== 8'd0) begin
            errors++; $display("FAIL glitch: frame %0d got y=%0d v=%0d required y=185 v=0", f, handline, hand_velocity);
         end
      end
   endtask

   task automatic test_clamp();
      int exp_y[4] = '{22, 20, 20, 20};
      int exp_v[4] = '{4, 8, 0, 0};
      // 185 - (1+..+12) - 7*12 = 23
      btn_up = 1'b1;
      repeat (DBL) step();
      repeat (19) wait_frame();
      checks++;
      if (handline !== 9'd23) begin
         errors++; $display("FAIL clamp_approach: got %0d required 23", handline);
      end
      btn_up = 1'b0;
      repeat (DBL) step();
      wait_frame();
      btn_up = 1'b1;
      repeat (DBL) step();
      for (int f = 0; f < 4; f++) begin
         wait_frame();
         checks++;
         if (handline !== exp_y[f][8:0] || hand_velocity !== exp_v[f][7:0]) begin
            errors++;
            $display("FAIL clamp_top: frame %0d got y=%0d v=%0d required y=%0d v=%0d", f, handline, hand_velocity, exp_y[f], exp_v[f]);
         end
      end
      btn_up = 1'b0;
      repeat (DBL) step();
      wait_frame();
      btn_down = 1'b1;
      repeat (DBL) step();
      repeat (30) wait_frame();
      for (int f = 0; f < 3; f++) begin
         wait_frame();
         checks++;
         if (handline !== 9'd300 || hand_velocity !== 8'd0) begin
            errors++; $display("FAIL clamp_bottom: frame %0d got y=%0d v=%0d required y=300 v=0", f, handline, hand_velocity);
         end
      end
      btn_down = 1'b0;
      repeat (DBL) step();
      wait_frame();
   endtask

   task automatic test_both();
      int exp_y[3] = '{299, 297, 294};
      btn_up = 1'b1;
      repeat (DBL) step();
      for (int f = 0; f < 3; f++) begin
         wait_frame();
         checks++;
         if (handline !== exp_y[f][8:0]) begin
            errors++; $display("FAIL both_setup: frame %0d got %0d required %0d", f, handline, exp_y[f]);
         end
      end
      btn_up = 1'b0;
      repeat (DBL) step();
      wait_frame();
      btn_up = 1'b1; btn_down = 1'b1;
      repeat (DBL) step();
      for (int f = 0; f < 2; f++) begin
         wait_frame();
         checks++;
         if (handline !== 9'd294 || hand_velocity !== 8'd0) begin
            errors++; $display("FAIL both_held: frame %0d got y=%0d v=%0d required y=294 v=0", f, handline, hand_velocity);
         end
      end
      btn_up = 1'b0;
      repeat (DBL) step();
      wait_frame();
      checks++;
      if (handline !== 9'd295 || hand_velocity !== 8'd0) begin
         errors++; $display("FAIL down_restart: got y=%0d v=%0d required y=295 v=0", handline, hand_velocity);
      end
      wait_frame();
      checks++;
      if (handline !== 9'd297 || hand_velocity !== 8'd0) begin
         errors++; $display("FAIL down_accel: got y=%0d v=%0d required y=297 v=0", handline, hand_velocity);
      end
      btn_down = 1'b0;
      repeat (DBL) step();
      wait_frame();
   endtask

   task automatic test_lock();
      int y_exp = 297;
      btn_up = 1'b1;
      repeat (DBL) step();
      for (int s = 1; s <= 6; s++) begin
         wait_frame();
         y_exp -= s;
         checks++;
         if (handline !== y_exp[8:0] || hand_velocity !== 8'(4 * s)) begin
            errors++; $display("FAIL lock_ramp: speed %0d got y=%0d v=%0d required y=%0d v=%0d", s, handline, hand_velocity, y_exp, 4 * s);
         end
      end
      lock = 1'b1;
      for (int f = 0; f < 2; f++) begin
         wait_frame();
         checks++;
         if (handline !== y_exp[8:0] || hand_velocity !== 8'd0) begin
            errors++; $display("FAIL lock_freeze: frame %0d got y=%0d v=%0d required y=%0d v=0", f, handline, hand_velocity, y_exp);
         end
      end
      lock = 1'b0;
      wait_frame();
      checks++;
      if (handline !== 9'(y_exp - 1) || hand_velocity !== 8'd4) begin
         errors++; $display("FAIL lock_resume: got y=%0d v=%0d required y=%0d v=4", handline, hand_velocity, y_exp - 1);
      end
      btn_up = 1'b0;
      repeat (DBL) step();
      wait_frame();
   endtask

   task automatic test_random();
      int hold;
      for (int seg = 0; seg < 200; seg++) begin
         btn_up   = ($urandom_range(0, 2) != 0);
         btn_down = ($urandom_range(0, 3) == 0);
         lock     = ($urandom_range(0, 9) == 0);
         rst      = ($urandom_range(0, 49) == 0);
         hold     = rst ? $urandom_range(1, 2) : $urandom_range(1, 14);
         for (int c = 0; c < hold; c++) begin
            step();
            checks++;
            if (handline !== 9'(m_y) || hand_velocity !== 8'(m_vel) || frame_tick !== (m_cnt == TICK_DIV - 1)) begin
               errors++;
               $display("FAIL random: seg %0d got y=%0d v=%0d t=%b required y=%0d v=%0d t=%b", seg, handline, hand_velocity, frame_tick, m_y, m_vel, (m_cnt == TICK_DIV - 1));
            end
         end
         rst = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; lock = 1'b0;
      model_reset();
      test_reset();
      test_hold_up();
      test_glitch();
      test_clamp();
      test_both();
      test_lock();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
